// File: rtl/timer_pkg.sv
// Shared types and constants for the DMG divider/timer block.
package timer_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } tstate_e;

    localparam logic [1:0] REG_DIV  = 2'd0;
    localparam logic [1:0] REG_TIMA = 2'd1;
    localparam logic [1:0] REG_TMA  = 2'd2;
    localparam logic [1:0] REG_TAC  = 2'd3;

    localparam int unsigned TAP_W = 4;

    // Counter bit watched by the timer for each TAC[1:0] clock-select value.
    localparam logic [TAP_W-1:0] TAC_TAP_IDX [4] = '{4'd9, 4'd3, 4'd5, 4'd7};

    function automatic logic [TAP_W-1:0] tac_tap_idx(input logic [1:0] sel);
        return TAC_TAP_IDX[sel];
    endfunction

endpackage

// File: rtl/fall_edge_det.sv
// Falling-edge detector fed with the next-cycle level, so the pulse lands in
// the same cycle that the registered level first reads low.
module fall_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_d,
    output logic fall_q
);

    logic sig_q;
    logic fall_d;

    always_comb begin
        fall_d = sig_q & ~sig_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q  <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            fall_q <= fall_d;
        end
    end

endmodule

// File: rtl/timer_sched.sv
// DMG system divider and programmable timer (FF04-FF07): TIMA sequencing,
// delayed TMA reload, timer interrupt and the 512 Hz APU frame tick.
module timer_sched
    import timer_pkg::*;
#(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned RELOAD_DELAY = 4,
    parameter int unsigned APU_TAP      = 12
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             ff04_ff07,
    input  logic [1:0]       a,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             irq_timer,
    output logic             apu_tick,
    output logic [DIV_W-1:0] div_q
);

    localparam int unsigned CNT_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;

    tstate_e          state_q, state_d;
    logic [DIV_W-1:0] div_d;
    logic [7:0]       tima_q, tima_d;
    logic [7:0]       tma_q, tma_d;
    logic [2:0]       tac_q, tac_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       dout_q, dout_d;
    logic             irq_q, irq_d;

    logic       wr_hit, rd_hit;
    logic       wr_div, wr_tima, wr_tma, wr_tac;
    logic       tap_d, apu_d;
    logic       inc_ev;
    logic [7:0] rd_val;

    assign wr_hit  = ff04_ff07 & cpu_wr;
    assign rd_hit  = ff04_ff07 & cpu_rd;
    assign wr_div  = wr_hit & (a == REG_DIV);
    assign wr_tima = wr_hit & (a == REG_TIMA);
    assign wr_tma  = wr_hit & (a == REG_TMA);
    assign wr_tac  = wr_hit & (a == REG_TAC);

    // Next-cycle divider and config; taps are taken from these so DIV/TAC
    // writes that pull a tap low are seen as ordinary falling edges.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        tac_d = tac_q;
        tma_d = tma_q;
        if (wr_div) begin
            div_d = '0;
        end
        if (wr_tac) begin
            tac_d = din[2:0];
        end
        if (wr_tma) begin
            tma_d = din;
        end
        tap_d = tac_d[2] & div_d[tac_tap_idx(tac_d[1:0])];
        apu_d = div_d[APU_TAP];
    end

    fall_edge_det u_tap_fall (
        .clk    (clk1),
        .reset  (reset),
        .sig_d  (tap_d),
        .fall_q (inc_ev)
    );

    fall_edge_det u_apu_fall (
        .clk    (clk1),
        .reset  (reset),
        .sig_d  (apu_d),
        .fall_q (apu_tick)
    );

    // TIMA sequencing: count, overflow hold, reload.
    always_comb begin
        state_d = state_q;
        tima_d  = tima_q;
        cnt_d   = cnt_q;
        irq_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (wr_tima) begin
                    tima_d = din;
                end else if (inc_ev) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        cnt_d   = CNT_W'(RELOAD_DELAY - 1);
                        state_d = OVF;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            OVF: begin
                if (wr_tima) begin
                    tima_d  = din;
                    state_d = RUN;
                end else if (cnt_q == '0) begin
                    tima_d  = tma_q;
                    irq_d   = 1'b1;
                    state_d = RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELOAD: begin
                state_d = RUN;
                if (wr_tma) begin
                    tima_d = din;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Register read port; returns pre-write values on a same-cycle write.
    always_comb begin
        rd_val = 8'h00;
        case (a)
            REG_DIV:  rd_val = div_q[DIV_W-1 -: 8];
            REG_TIMA: rd_val = tima_q;
            REG_TMA:  rd_val = tma_q;
            REG_TAC:  rd_val = {5'b11111, tac_q};
            default:  rd_val = 8'h00;
        endcase
        dout_d = rd_hit ? rd_val : dout_q;
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q <= RUN;
            div_q   <= '0;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            cnt_q   <= '0;
            dout_q  <= 8'h00;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            irq_q   <= irq_d;
        end
    end

    assign dout      = dout_q;
    assign irq_timer = irq_q;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: cycle model checked every cycle plus directed
// scenarios with hand-computed register values.
module tb_timer_sched;

    localparam int unsigned RELOAD_DELAY = 4;

    logic        clk1;
    logic        reset;
    logic        ff04_ff07;
    logic [1:0]  a;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        irq_timer;
    logic        apu_tick;
    logic [15:0] div_q;

    timer_sched #(
        .DIV_W        (16),
        .RELOAD_DELAY (RELOAD_DELAY),
        .APU_TAP      (12)
    ) dut (
        .clk1      (clk1),
        .reset     (reset),
        .ff04_ff07 (ff04_ff07),
        .a         (a),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .din       (din),
        .dout      (dout),
        .irq_timer (irq_timer),
        .apu_tick  (apu_tick),
        .div_q     (div_q)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_tests;
    int n_fail;
    bit armed;

    // Model state: register values as seen during the current cycle.
    logic [15:0] m_div;
    logic [7:0]  m_tima, m_tma, m_dout;
    logic [2:0]  m_tac;
    bit          m_irq, m_reload, m_prev_tap, m_prev_apu;
    int          m_ovf_left;

    int          apu_cnt, irq_cnt;
    logic [15:0] apu_div, irq_div;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tap_of(input logic [15:0] d, input logic [2:0] t);
        logic [3:0] idx;
        case (t[1:0])
            2'd0: idx = 4'd9;
            2'd1: idx = 4'd3;
            2'd2: idx = 4'd5;
            default: idx = 4'd7;
        endcase
        return t[2] && d[idx];
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] off);
        case (off)
            2'd0: return m_div[15:8];
            2'd1: return m_tima;
            2'd2: return m_tma;
            default: return {5'b11111, m_tac};
        endcase
    endfunction

    task automatic model_reset();
        m_div = 16'h0; m_tima = 8'h0; m_tma = 8'h0; m_tac = 3'b0; m_dout = 8'h0;
        m_irq = 1'b0; m_reload = 1'b0; m_prev_tap = 1'b0; m_prev_apu = 1'b0;
        m_ovf_left = 0;
    endtask

    // Compare DUT against model for this cycle, then advance the model.
    task automatic cycle_compare();
        bit          tap_c, ev, apu_e, wr, rd;
        logic [7:0]  n_tima;
        int          n_ovf;
        bit          n_reload, n_irq;
        tap_c = tap_of(m_div, m_tac);
        ev    = m_prev_tap && !tap_c;
        apu_e = m_prev_apu && !m_div[12];
        check("div_q", div_q, m_div);
        check("dout", dout, m_dout);
        check("irq_timer", irq_timer, m_irq);
        check("apu_tick", apu_tick, apu_e);
        if (apu_tick === 1'b1) begin apu_cnt++; apu_div = div_q; end
        if (irq_timer === 1'b1) begin irq_cnt++; irq_div = div_q; end
        if (reset) begin
            model_reset();
        end else begin
            wr = ff04_ff07 && cpu_wr;
            rd = ff04_ff07 && cpu_rd;
            n_tima = m_tima; n_ovf = m_ovf_left; n_reload = 1'b0; n_irq = 1'b0;
            if (m_ovf_left > 0) begin
                if (wr && a == 2'd1) begin
                    n_tima = din; n_ovf = 0;
                end else if (m_ovf_left == 1) begin
                    n_tima = m_tma; n_ovf = 0; n_reload = 1'b1; n_irq = 1'b1;
                end else begin
                    n_ovf = m_ovf_left - 1;
                end
            end else if (m_reload) begin
                if (wr && a == 2'd2) n_tima = din;
            end else begin
                if (wr && a == 2'd1) begin
                    n_tima = din;
                end else if (ev) begin
                    if (m_tima == 8'hFF) begin
                        n_tima = 8'h00; n_ovf = RELOAD_DELAY;
                    end else begin
                        n_tima = m_tima + 8'd1;
                    end
                end
            end
            if (rd) m_dout = model_read(a);
            m_prev_tap = tap_c;
            m_prev_apu = m_div[12];
            m_div      = (wr && a == 2'd0) ? 16'h0 : m_div + 16'd1;
            if (wr && a == 2'd3) m_tac = din[2:0];
            if (wr && a == 2'd2) m_tma = din;
            m_tima = n_tima; m_ovf_left = n_ovf; m_reload = n_reload; m_irq = n_irq;
        end
    endtask

    task automatic cyc(input bit hit, input bit wr, input bit rd,
                       input logic [1:0] off, input logic [7:0] d);
        ff04_ff07 = hit; cpu_wr = wr; cpu_rd = rd; a = off; din = d;
        @(posedge clk1); #1;
        ff04_ff07 = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic rd_cyc(input logic [1:0] off, output logic [7:0] v);
        cyc(1'b1, 1'b0, 1'b1, off, 8'h00);
        v = dout;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk1); #1; end
    endtask

    // Leaves the timer with div_q=1, TAC=3'b101 (bit 3), given TMA and TIMA.
    task automatic setup(input logic [7:0] tma_v, input logic [7:0] tima_v);
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, tma_v);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, tima_v);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 8'h05);
    endtask

    logic [7:0] v;
    logic [7:0] exp_s2 [8];
    int         irq_base;

    initial begin
        n_tests = 0; n_fail = 0; armed = 1'b0;
        apu_cnt = 0; irq_cnt = 0; apu_div = 16'h0; irq_div = 16'h0;
        reset = 1'b1; ff04_ff07 = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; a = 2'd0; din = 8'h00;
        model_reset();
        exp_s2[0] = 8'hFF; exp_s2[1] = 8'hFF; exp_s2[2] = 8'h00; exp_s2[3] = 8'h00;
        exp_s2[4] = 8'h00; exp_s2[5] = 8'h00; exp_s2[6] = 8'hAB; exp_s2[7] = 8'hAB;
        fork
            forever begin
                @(negedge clk1);
                if (armed) cycle_compare();
            end
        join_none
        @(posedge clk1); #1;
        armed = 1'b1;
        check("reset_div", div_q, 16'h0000);
        check("reset_dout", dout, 8'h00);
        idle(2);
        reset = 1'b0;

        // Free run: div[12] first falls at 0x2000.
        idle(8192);
        check("s1_div", div_q, 16'h2000);
        check("s1_apu_now", apu_tick, 1'b1);
        rd_cyc(2'd0, v);
        check("s1_div_read", v, 8'h20);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        rd_cyc(2'd0, v);
        check("s1_nohit_wr", v, 8'h20);
        check("s1_apu_cnt", apu_cnt, 1);
        check("s1_apu_div", apu_div, 16'h2000);

        // Overflow and delayed reload of 0xAB.
        irq_base = irq_cnt;
        setup(8'hAB, 8'hFE);
        idle(30);
        for (int i = 0; i < 8; i++) begin
            rd_cyc(2'd1, v);
            check($sformatf("s2_tima_%0d", 31 + i), v, exp_s2[i]);
        end
        check("s2_irq_cnt", irq_cnt - irq_base, 1);
        check("s2_irq_div", irq_div, 16'd37);

        // TIMA write in the 2nd overflow cycle cancels reload and irq.
        irq_base = irq_cnt;
        setup(8'hCC, 8'hFF);
        idle(17);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 8'h55);
        for (int i = 0; i < 4; i++) begin
            rd_cyc(2'd1, v);
            check($sformatf("s3_tima_%0d", i), v, 8'h55);
        end
        idle(10);
        check("s3_no_irq", irq_cnt - irq_base, 0);
        rd_cyc(2'd1, v);
        check("s3_tima_after", v, 8'h56);

        // TMA write during RELOAD also loads TIMA.
        irq_base = irq_cnt;
        setup(8'h10, 8'hFF);
        idle(20);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 8'h77);
        rd_cyc(2'd1, v);
        check("s4_tima", v, 8'h77);
        rd_cyc(2'd2, v);
        check("s4_tma", v, 8'h77);
        check("s4_irq_cnt", irq_cnt - irq_base, 1);
        check("s4_irq_div", irq_div, 16'd21);
        cyc(1'b1, 1'b1, 1'b1, 2'd2, 8'h33);
        check("s4_rw_same", dout, 8'h77);
        rd_cyc(2'd2, v);
        check("s4_tma_new", v, 8'h33);

        // TIMA write during RELOAD is ignored.
        setup(8'h10, 8'hFF);
        idle(20);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 8'h11);
        rd_cyc(2'd1, v);
        check("s4b_tima", v, 8'h10);

        // DIV write and TAC disable while the tap is high each add one.
        setup(8'h00, 8'h40);
        idle(8);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'h9C);
        idle(1);
        rd_cyc(2'd1, v);
        check("s5_div_wr_inc", v, 8'h41);
        idle(6);
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 8'h00);
        idle(1);
        rd_cyc(2'd1, v);
        check("s5_tac_wr_inc", v, 8'h42);
        idle(20);
        rd_cyc(2'd1, v);
        check("s5_disabled", v, 8'h42);

        // Reset in the middle of an overflow window.
        setup(8'h99, 8'hFF);
        idle(17);
        irq_base = irq_cnt;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("s6_dout_rst", dout, 8'h00);
        idle(10);
        check("s6_no_irq", irq_cnt - irq_base, 0);
        rd_cyc(2'd0, v);
        check("s6_div", v, 8'h00);
        rd_cyc(2'd1, v);
        check("s6_tima", v, 8'h00);
        rd_cyc(2'd2, v);
        check("s6_tma", v, 8'h00);
        rd_cyc(2'd3, v);
        check("s6_tac", v, 8'hF8);

        idle(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
